// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: computes (lhs - rhs - bin) mod 2^WIDTH and the
// unsigned borrow-out, one bit per clock, LSB first, using a single
// full-subtractor cell and a borrow flop. The operation takes WIDTH clocks
// from the accept edge to out_valid.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. in_ready is 1 only in IDLE and out_valid is 1
// only in DONE, so the two are never asserted together; operand inputs are
// ignored outside IDLE and need not be held after the accept edge. out/bout
// stay stable while out_valid is high and out_ready is low.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 1)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   operands presented
//   in_ready   block can accept operands (decode of state == IDLE)
//   lhs        minuend
//   rhs        subtrahend
//   bin        borrow-in
//   out_valid  result available (decode of state == DONE)
//   out_ready  consumer accepts the result
//   out        difference, registered, holds the last result in IDLE
//   bout       borrow-out, 1 iff lhs < rhs + bin (unsigned), registered
//   dbg_state  current FSM state (0 = IDLE, 1 = SHIFT, 2 = DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             bout,
    output logic [1:0]       dbg_state
);

    // One extra counter bit keeps WIDTH = 1 legal ($clog2(1) = 0).
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;       // minuend shift register
    logic [WIDTH-1:0] b_q;       // subtrahend shift register
    logic [WIDTH-1:0] r_q;       // result shift register, filled from the MSB end
    logic             borrow_q;  // borrow carried between bit positions
    logic [CW-1:0]    cnt_q;     // number of bits already processed

    // Full-subtractor cell on the current LSBs.
    logic             diff_bit;
    logic             borrow_next;
    logic [WIDTH-1:0] r_next;

    always_comb begin
        diff_bit    = a_q[0] ^ b_q[0] ^ borrow_q;
        borrow_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
    end

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 of the
    // first step has reached R[0]. A one-bit result is just the cell output.
    generate
        if (WIDTH == 1) begin : g_r_one
            assign r_next = diff_bit;
        end else begin : g_r_wide
            assign r_next = {diff_bit, r_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            out      <= '0;
            bout     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= lhs;
                        b_q      <= rhs;
                        borrow_q <= bin;
                        r_q      <= '0;
                        cnt_q    <= '0;
                        state    <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_q      <= r_next;
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    borrow_q <= borrow_next;
                    cnt_q    <= cnt_q + CNT_ONE;
                    // Final bit: publish the completed result together with
                    // the borrow leaving the MSB position.
                    if (cnt_q == CNT_LAST) begin
                        out   <= r_next;
                        bout  <= borrow_next;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Three independent DUT instances (WIDTH = 1, 2, 8) share one clock. Each has
// its own reset, driver, scoreboard queue and monitor. Directed scenarios run
// on WIDTH = 2; exhaustive/random sweeps run on every width.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit done [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W = (gi == 0) ? 1 : (gi == 1) ? 2 : 8;

    // ---------------- DUT and its signals ----------------
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] lhs = '0;
    logic [W-1:0] rhs = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         bout;
    logic [1:0]   dbg_state;

    int   rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
    logic rnd_bit = 1'b1;
    always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);
    assign out_ready = (rdy_mode == 2) ? rnd_bit : (rdy_mode == 1);

    serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .lhs       (lhs),
      .rhs       (rhs),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .bout      (bout),
      .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];  // expected {bout, out}
    int         acc_q[$];  // cycle number of the accept edge
    logic [W:0] held = '0;
    logic       prev_valid = 1'b0;
    int         hs_cyc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
      vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("FAIL w%0d %s: got %0h, expected %0h (t=%0t)", W, name, got, expv, $time);
      end
    endtask

    task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL w%0d %s: bound expired (t=%0t)", W, name, $time);
    endtask

    // Reference: W+1-bit two's-complement difference; its top bit is the borrow.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] l, input logic [W-1:0] r,
                                           input logic b);
      logic [W:0] lx, rx, bx;
      lx = {1'b0, l};
      rx = {1'b0, r};
      bx = '0;
      bx[0] = b;
      return lx - rx - bx;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input logic b,
                        input bit push, output int acc);
      int n;
      n = 0;
      acc = -1;
      @(negedge clk);
      while (!in_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        fail("in_ready_wait");
        return;
      end
      lhs = l;
      rhs = r;
      bin = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      in_valid = 1'b0;
      lhs = W'($urandom);  // inputs need not be held after the accept edge
      rhs = W'($urandom);
      bin = 1'($urandom);
      if (push) begin
        exp_q.push_back(ref_sub(l, r, b));
        acc_q.push_back(acc);
      end
    endtask

    task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0 || !in_ready) fail("drain");
    endtask

    task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", 64'(out), 64'd0);
      check("reset_bout", 64'(bout), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_state", 64'(dbg_state), 64'd0);
      rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
      if (rst_n) begin
        if (in_ready && out_valid) check("ready_valid_exclusive", 64'd1, 64'd0);
        if (out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            logic [W:0] e;
            int a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("result", 64'({bout, out}), 64'(e));
            check("latency", 64'(cyc - a), 64'(W));
            held = e;
          end
        end else if (out_valid) begin
          check("result_stable", 64'({bout, out}), 64'(held));
        end
        if (out_valid && out_ready) hs_cyc = cyc + 1;
      end
      prev_valid = rst_n && out_valid;
    end

    // ---------------- stimulus ----------------
    if (W == 2) begin : g_directed
      initial begin
        int acc1, acc2, n;
        do_reset();

        // Single accept, then SHIFT with in_ready low.
        rdy_mode = 1;
        send(2'd1, 2'd3, 1'b1, 1'b1, acc1);
        @(negedge clk);
        check("shift_in_ready", 64'(in_ready), 64'd0);
        check("shift_state", 64'(dbg_state), 64'd1);
        wait_drain();

        // Back-to-back: next accept exactly one cycle after the out-handshake.
        send(2'd3, 2'd1, 1'b0, 1'b1, acc1);
        send(2'd2, 2'd2, 1'b1, 1'b1, acc2);
        check("b2b_accept_after_hs", 64'(acc2), 64'(hs_cyc + 1));
        wait_drain();

        // Backpressure with ignored in_valid pulses.
        rdy_mode = 0;
        send(2'd0, 2'd0, 1'b0, 1'b1, acc1);
        n = 0;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        if (!out_valid) fail("bp_valid_wait");
        for (int i = 0; i < 5; i++) begin
          check("bp_out_valid", 64'(out_valid), 64'd1);
          check("bp_out", 64'({bout, out}), 64'd0);
          in_valid = (i % 2 == 0);
          lhs = 2'($urandom);
          rhs = 2'($urandom);
          @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_state_done", 64'(dbg_state), 64'd2);
        rdy_mode = 1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_state", 64'(dbg_state), 64'd0);

        // Result held in IDLE, then a reset in the middle of an operation.
        send(2'd1, 2'd0, 1'b0, 1'b1, acc1);
        wait_drain();
        check("idle_holds_out", 64'(out), 64'd1);
        send(2'd3, 2'd0, 1'b0, 1'b0, acc1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out", 64'(out), 64'd0);
        check("midreset_bout", 64'(bout), 64'd0);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
          @(negedge clk);
          check("post_reset_no_valid", 64'(out_valid), 64'd0);
        end
        send(2'd1, 2'd0, 1'b0, 1'b1, acc1);
        wait_drain();

        // Exhaustive sweep with random backpressure.
        rdy_mode = 2;
        for (int l = 0; l < 4; l++)
          for (int r = 0; r < 4; r++)
            for (int b = 0; b < 2; b++)
              send(2'(l), 2'(r), 1'(b), 1'b1, acc1);
        wait_drain();
        check("w2_queue_empty", 64'(exp_q.size()), 64'd0);
        done[gi] = 1'b1;
      end
    end else if (W == 1) begin : g_one
      initial begin
        int acc;
        do_reset();
        rdy_mode = 1;
        send(1'b0, 1'b1, 1'b1, 1'b1, acc);
        wait_drain();
        send(1'b1, 1'b0, 1'b0, 1'b1, acc);
        wait_drain();
        rdy_mode = 2;
        for (int k = 0; k < 8; k++) send(1'(k >> 2), 1'(k >> 1), 1'(k), 1'b1, acc);
        wait_drain();
        check("w1_queue_empty", 64'(exp_q.size()), 64'd0);
        done[gi] = 1'b1;
      end
    end else begin : g_random
      initial begin
        int acc;
        do_reset();
        rdy_mode = 2;
        send(8'h00, 8'hff, 1'b1, 1'b1, acc);
        send(8'hff, 8'h00, 1'b0, 1'b1, acc);
        send(8'h80, 8'h80, 1'b1, 1'b1, acc);
        for (int i = 0; i < 1000; i++)
          send(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, acc);
        wait_drain();
        check("w8_queue_empty", 64'(exp_q.size()), 64'd0);
        done[gi] = 1'b1;
      end
    end
  end

  // ---------------- final report ----------------
  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 80000) begin
      @(posedge clk);
      n++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      vectors++;
      miscompares++;
      $display("FAIL global_timeout: done=%0d%0d%0d, required 111", done[2], done[1], done[0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
